// File: rtl/packet_tx_pkg.sv
// Shared constants and state enumeration for the packet_tx transmit path.
package packet_tx_pkg;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam int          PRE_LEN         = 7;
    localparam int          FCS_LEN         = 4;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        BODY,
        PAD,
        FCS,
        GAP
    } tx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (reflected) update over one byte, LSB of the byte first.
module crc32_d8
    import packet_tx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port (1-cycle latency).
module ram #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/packet_tx.sv
// Byte-serial Ethernet frame transmitter: buffers one body, then emits preamble, SFD,
// body, zero padding, CRC-32 FCS and inter-frame gap on a GMII-style data/enable pair.
module packet_tx
    import packet_tx_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int MIN_LEN = 60,
    parameter int IFG     = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  wr_data,
    input  logic        wr_en,
    input  logic        send,
    output logic        ready,
    output logic        overflow,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic [15:0] frame_count
);

    localparam int               LEN_W     = ADDR_W + 1;
    localparam logic [LEN_W-1:0] CAPACITY  = LEN_W'(1) << ADDR_W;
    localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] PRE_LAST  = LEN_W'(PRE_LEN - 1);
    localparam logic [LEN_W-1:0] FCS_LAST  = LEN_W'(FCS_LEN - 1);
    // tx_data/tx_en lag the state by one cycle, so the IDLE cycle that accepts
    // the next send also shows as a gap cycle; the GAP state covers the rest.
    localparam logic [LEN_W-1:0] GAP_LAST  = (IFG > 1) ? LEN_W'(IFG - 2) : '0;

    tx_state_t         state, state_next;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  wr_ptr;
    logic [LEN_W-1:0]  frame_len;
    logic [LEN_W-1:0]  pad_len;
    logic [LEN_W-1:0]  send_len;
    logic              wr_ok;
    logic              wr_drop;
    logic              send_ok;
    logic              gap_done;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [31:0]       crc;
    logic [31:0]       crc_next;
    logic [31:0]       fcs_word;
    logic [7:0]        fcs_byte;
    logic [7:0]        crc_byte;

    assign ready    = (state == IDLE);
    assign wr_ok    = wr_en && ready && (wr_ptr != CAPACITY);
    assign wr_drop  = wr_en && !wr_ok;
    assign send_len = wr_ptr + LEN_W'(wr_ok);
    assign send_ok  = send && ready && (send_len != '0);
    assign pad_len  = (frame_len < MIN_LEN_L) ? (MIN_LEN_L - frame_len) : '0;
    assign gap_done = (state == GAP) && (cnt == GAP_LAST);

    // Byte 0 is addressed during SFD; each BODY cycle prefetches the following byte.
    assign rd_addr  = (state == BODY) ? ADDR_W'(cnt + 1'b1) : '0;
    assign crc_byte = (state == BODY) ? rd_data : 8'h00;
    assign fcs_word = ~crc;
    assign fcs_byte = fcs_word[{cnt[1:0], 3'b000} +: 8];

    ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(8)
    ) buffer (
        .clk  (clk),
        .we   (wr_ok),
        .waddr(wr_ptr[ADDR_W-1:0]),
        .wdata(wr_data),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    crc32_d8 crc_calc (
        .crc_in (crc),
        .data   (crc_byte),
        .crc_out(crc_next)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (send_ok) state_next = PRE;
            PRE:  if (cnt == PRE_LAST) state_next = SFD;
            SFD:  state_next = BODY;
            BODY: if (cnt == frame_len - 1'b1) state_next = (pad_len != '0) ? PAD : FCS;
            PAD:  if (cnt == pad_len - 1'b1) state_next = FCS;
            FCS:  if (cnt == FCS_LAST) state_next = GAP;
            GAP:  if (gap_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            frame_len   <= '0;
            overflow    <= 1'b0;
            frame_count <= '0;
            crc         <= CRC32_INIT;
        end else begin
            if (gap_done) begin
                wr_ptr      <= '0;
                frame_count <= frame_count + 16'd1;
            end else if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (send_ok) begin
                frame_len <= send_len;
                overflow  <= 1'b0;
                crc       <= CRC32_INIT;
            end else begin
                if (wr_drop) begin
                    overflow <= 1'b1;
                end
                if (state == BODY || state == PAD) begin
                    crc <= crc_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_data <= 8'h00;
            tx_en   <= 1'b0;
        end else begin
            case (state)
                PRE:  begin tx_data <= ETH_PREAMBLE; tx_en <= 1'b1; end
                SFD:  begin tx_data <= ETH_SFD;      tx_en <= 1'b1; end
                BODY: begin tx_data <= rd_data;      tx_en <= 1'b1; end
                PAD:  begin tx_data <= 8'h00;        tx_en <= 1'b1; end
                FCS:  begin tx_data <= fcs_byte;     tx_en <= 1'b1; end
                default: begin tx_data <= 8'h00;     tx_en <= 1'b0; end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_tx.sv
// Self-checking bench for packet_tx: random bodies checked against a table-driven
// CRC-32 frame model; a second instance runs with MIN_LEN=0 for the known vector.
module tb_packet_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] wr_data [2];
    logic       wr_en [2];
    logic       send [2];
    logic       ready [2];
    logic       overflow [2];
    logic [7:0] tx_data [2];
    logic       tx_en [2];
    logic [15:0] frame_count [2];

    int checks = 0;
    int passes = 0;

    logic [7:0]  body_q[$];
    logic [7:0]  msg_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [31:0] crc_table [256];
    int          start_wait;

    always #5 clk = ~clk;

    packet_tx dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_data    (wr_data[0]),
        .wr_en      (wr_en[0]),
        .send       (send[0]),
        .ready      (ready[0]),
        .overflow   (overflow[0]),
        .tx_data    (tx_data[0]),
        .tx_en      (tx_en[0]),
        .frame_count(frame_count[0])
    );

    packet_tx #(.MIN_LEN(0)) dut0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_data    (wr_data[1]),
        .wr_en      (wr_en[1]),
        .send       (send[1]),
        .ready      (ready[1]),
        .overflow   (overflow[1]),
        .tx_data    (tx_data[1]),
        .tx_en      (tx_en[1]),
        .frame_count(frame_count[1])
    );

    task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One negedge step; optionally keeps send and wr_en asserted every cycle.
    task tick(input int d, input bit hold);
        @(negedge clk);
        if (hold) begin
            send[d]    = 1'b1;
            wr_en[d]   = 1'b1;
            wr_data[d] = 8'hA5;
        end
    endtask

    task applyStimulus(input int d, input bit merge_last, input bit do_send);
        foreach (body_q[i]) begin
            @(negedge clk);
            wr_en[d]   = 1'b1;
            wr_data[d] = body_q[i];
            send[d]    = do_send && merge_last && (i == body_q.size() - 1);
        end
        @(negedge clk);
        wr_en[d] = 1'b0;
        send[d]  = 1'b0;
        if (do_send && !merge_last) begin
            send[d] = 1'b1;
            @(negedge clk);
            send[d] = 1'b0;
        end
    endtask

    // Frame model: preamble, SFD, body, zero pad to min_len, complemented CRC LSB first.
    task build_expected(input int min_len);
        logic [31:0] c;
        exp_q = {};
        msg_q = body_q;
        while (msg_q.size() < min_len) msg_q.push_back(8'h00);
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        c = 32'hFFFFFFFF;
        foreach (msg_q[i]) begin
            exp_q.push_back(msg_q[i]);
            c = crc_table[c[7:0] ^ msg_q[i]] ^ (c >> 8);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    endtask

    task capture_frame(input int d, input bit hold);
        int n;
        got_q = {};
        n = 0;
        while (tx_en[d] !== 1'b1 && n < 64) begin
            tick(d, hold);
            n++;
        end
        start_wait = n;
        checkOutput("frame_start", tx_en[d], 1);
        n = 0;
        while (tx_en[d] === 1'b1 && n < 4000) begin
            got_q.push_back(tx_data[d]);
            tick(d, hold);
            n++;
        end
    endtask

    task check_frame(input string pfx);
        int bad;
        bad = -1;
        checkOutput({pfx, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
        end
        checkOutput({pfx, "_first_bad_byte"}, bad, -1);
    endtask

    task wait_ready(input int d);
        int n;
        n = 0;
        while (ready[d] !== 1'b1 && n < 200) begin
            tick(d, 0);
            n++;
        end
        checkOutput("ready_return", ready[d], 1);
    endtask

    task count_tx(input int d, input int cycles, output int hi);
        hi = 0;
        repeat (cycles) begin
            tick(d, 0);
            if (tx_en[d] === 1'b1) hi++;
        end
    endtask

    task random_body(input int n);
        body_q = {};
        repeat (n) body_q.push_back(8'($urandom));
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int hi;
        int gap_n;
        int ready_at;
        logic [31:0] c;

        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_table[n] = c;
        end

        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            wr_data[d] = 8'h00;
            wr_en[d]   = 1'b0;
            send[d]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", ready[0], 1);
        checkOutput("reset_overflow", overflow[0], 0);
        checkOutput("reset_tx_en", tx_en[0], 0);
        checkOutput("reset_tx_data", tx_data[0], 0);
        checkOutput("reset_frame_count", frame_count[0], 0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] reset in the middle of a body");
        random_body(10);
        applyStimulus(0, 0, 1);
        hi = 0;
        while (tx_en[0] !== 1'b1 && hi < 64) begin
            tick(0, 0);
            hi++;
        end
        repeat (13) tick(0, 0);
        checkOutput("mid_body_byte5", tx_data[0], body_q[5]);
        reset_n = 1'b0;
        tick(0, 0);
        checkOutput("midreset_tx_en", tx_en[0], 0);
        checkOutput("midreset_tx_data", tx_data[0], 0);
        checkOutput("midreset_ready", ready[0], 1);
        checkOutput("midreset_frame_count", frame_count[0], 0);
        reset_n = 1'b1;
        count_tx(0, 30, hi);
        checkOutput("midreset_no_fcs", hi, 0);
        random_body(3);
        applyStimulus(0, 0, 1);
        capture_frame(0, 0);
        build_expected(60);
        check_frame("fresh3");
        wait_ready(0);
        checkOutput("fresh3_frame_count", frame_count[0], 1);

        $display("[TB] padded frame, last write coincides with send");
        body_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                   8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h06};
        applyStimulus(0, 1, 1);
        capture_frame(0, 0);
        build_expected(60);
        check_frame("pad");
        checkOutput("pad_tx_en_cycles", got_q.size(), 72);
        wait_ready(0);
        checkOutput("pad_frame_count", frame_count[0], 2);

        $display("[TB] writes and sends while busy");
        random_body(20);
        applyStimulus(0, 0, 1);
        fork
            capture_frame(0, 0);
            begin
                repeat (30) begin
                    @(negedge clk);
                    wr_en[0]   = 1'b1;
                    wr_data[0] = 8'($urandom);
                    send[0]    = 1'($urandom_range(1));
                end
                @(negedge clk);
                wr_en[0] = 1'b0;
                send[0]  = 1'b0;
            end
        join
        build_expected(60);
        check_frame("busy");
        checkOutput("busy_overflow_sticky", overflow[0], 1);
        wait_ready(0);
        count_tx(0, 20, hi);
        checkOutput("busy_send_ignored", hi, 0);
        send[0] = 1'b1;
        tick(0, 0);
        send[0] = 1'b0;
        count_tx(0, 20, hi);
        checkOutput("empty_send_no_tx", hi, 0);
        checkOutput("empty_send_ready", ready[0], 1);
        checkOutput("empty_send_overflow_kept", overflow[0], 1);
        checkOutput("busy_frame_count", frame_count[0], 3);

        $display("[TB] CRC vector then back-to-back sends (MIN_LEN=0)");
        body_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        applyStimulus(1, 0, 1);
        capture_frame(1, 1);
        checkOutput("send_latency", start_wait, 1);
        build_expected(0);
        check_frame("crc_vec");
        checkOutput("crc_vec_fcs", {got_q[20], got_q[19], got_q[18], got_q[17]}, 32'hCBF43926);
        gap_n = 0;
        ready_at = -1;
        while (tx_en[1] !== 1'b1 && gap_n < 100) begin
            if (ready[1] === 1'b1 && ready_at < 0) ready_at = gap_n;
            tick(1, 1);
            gap_n++;
        end
        checkOutput("b2b_gap_cycles", gap_n, 12);
        checkOutput("b2b_ready_to_preamble", gap_n - ready_at, 2);
        capture_frame(1, 1);
        send[1]  = 1'b0;
        wr_en[1] = 1'b0;
        body_q = '{8'hA5};
        build_expected(0);
        check_frame("b2b_second");
        wait_ready(1);
        checkOutput("b2b_frame_count", frame_count[1], 2);

        $display("[TB] buffer fill past capacity");
        random_body(2049);
        applyStimulus(0, 0, 0);
        checkOutput("fill_overflow", overflow[0], 1);
        void'(body_q.pop_back());
        send[0] = 1'b1;
        @(negedge clk);
        send[0] = 1'b0;
        capture_frame(0, 0);
        checkOutput("fill_overflow_cleared", overflow[0], 0);
        build_expected(60);
        check_frame("fill");
        wait_ready(0);

        $display("[TB] maximum 1514-byte body");
        random_body(1514);
        applyStimulus(0, 0, 1);
        capture_frame(0, 0);
        checkOutput("max_tx_en_cycles", got_q.size(), 1526);
        build_expected(60);
        check_frame("max");
        wait_ready(0);
        checkOutput("max_frame_count", frame_count[0], 5);

        $display("[TB] frame counter wrap");
        @(negedge clk);
        force dut.frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count;
        random_body(3);
        applyStimulus(0, 0, 1);
        capture_frame(0, 0);
        build_expected(60);
        check_frame("wrap");
        wait_ready(0);
        checkOutput("wrap_frame_count", frame_count[0], 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
